// File: rtl/cpu_oci_monitor_access.sv
// rtl/cpu_oci_monitor_access.sv - OCI memory monitor: JTAG ocimem actions to single-word Avalon-MM transfers
module cpu_oci_monitor_access #(
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } state_t;

  // The counter saturates at TIMEOUT_CYC-1 before aborting, so 16 bits covers the full range.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              wr_mode;
  logic              autoinc;
  logic [15:0]       tmo_cnt;

  logic busy;
  logic any_strobe;
  logic start_rd;
  logic start_wr;
  logic done;
  logic timeout;

  // jdo bits outside the address/mode/data fields carry nothing for this block.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  assign busy       = (state != IDLE);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Bus outputs come straight from registered state so requests stay stable while stalled.
  assign avm_read      = (state == RD_REQ);
  assign avm_write     = (state == WR_REQ);
  assign avm_address   = addr;
  assign avm_writedata = MonDReg;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: strobe decode with action_a > action_b > no_action_a, and transfer termination.
  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          state_nxt = IDLE;
        end else if (take_action_ocimem_b) begin
          if (wr_mode) begin
            start_wr = 1'b1;
          end else begin
            start_rd = 1'b1;
          end
        end else if (take_no_action_ocimem_a && !wr_mode) begin
          start_rd = 1'b1;
        end
        if (start_wr) begin
          state_nxt = WR_REQ;
        end else if (start_rd) begin
          state_nxt = RD_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        if (!avm_waitrequest) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/mode registers, data register, status flags and the stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr          <= '0;
      wr_mode       <= 1'b0;
      autoinc       <= 1'b0;
      tmo_cnt       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (!busy && take_action_ocimem_a) begin
        addr          <= jdo[17 +: ADDR_W];
        wr_mode       <= jdo[35];
        autoinc       <= jdo[34];
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
      end
      if (start_wr) begin
        MonDReg <= jdo[34:3];
      end
      if (start_wr || start_rd) begin
        monitor_ready <= 1'b0;
        tmo_cnt       <= '0;
      end
      if (busy) begin
        if (avm_waitrequest) begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
        // Strobes arriving mid-transfer are lost; flag it so the host knows to retry.
        if (any_strobe) begin
          monitor_error <= 1'b1;
        end
        if (done) begin
          monitor_ready <= 1'b1;
          if (state == RD_REQ) begin
            MonDReg <= avm_readdata;
          end
          if (autoinc) begin
            addr <= addr + 1'b1;
          end
        end
        if (timeout) begin
          monitor_ready <= 1'b1;
          monitor_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_oci_monitor_access.sv
// tb/tb_cpu_oci_monitor_access.sv - self-checking bench for cpu_oci_monitor_access
module tb_cpu_oci_monitor_access;

  localparam int ADDR_W = 9;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  always #5 clk = ~clk;

  cpu_oci_monitor_access #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the host-visible monitor state.
  int          m_addr;
  bit          m_wr;
  bit          m_inc;
  logic [31:0] m_mon;
  bit          m_ready;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".read"},  32'(avm_read), 32'd0);
    chk({tag, ".write"}, 32'(avm_write), 32'd0);
    chk({tag, ".addr"},  32'(avm_address), 32'(m_addr));
    chk({tag, ".mon"},   MonDReg, m_mon);
    chk({tag, ".ready"}, 32'(monitor_ready), 32'(m_ready));
    chk({tag, ".error"}, 32'(monitor_error), 32'(m_err));
  endtask

  task automatic model_reset();
    m_addr = 0; m_wr = 0; m_inc = 0; m_mon = '0; m_ready = 0; m_err = 0;
  endtask

  task automatic action_a(input bit wr, input bit inc, input int addr);
    @(negedge clk);
    jdo = {6'($urandom), $urandom};
    jdo[35] = wr;
    jdo[34] = inc;
    jdo[25:17] = 9'(addr);
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    m_addr = addr % (1 << ADDR_W); m_wr = wr; m_inc = inc; m_ready = 0; m_err = 0;
    check_idle("act_a");
  endtask

  // kind 1: action_b, kind 2: no_action_a. busy_at>0 pulses action_b in that request cycle.
  task automatic transfer(input int kind, input int stalls, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int busy_at, input string tag);
    bit is_wr;
    bit launches;
    int cycles;
    int exp_cycles;
    is_wr    = m_wr && (kind == 1);
    launches = (kind == 1) || !m_wr;
    @(negedge clk);
    jdo = {6'($urandom), $urandom};
    if (kind == 1) jdo[34:3] = wdata;
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    avm_readdata    = ~rdata;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    if (is_wr) m_mon = wdata;
    cycles = 0;
    while ((avm_read || avm_write) && cycles < 100) begin
      cycles++;
      chk({tag, ".req_addr"}, 32'(avm_address), 32'(m_addr));
      chk({tag, ".req_wr"},   32'(avm_write), 32'(is_wr));
      chk({tag, ".req_rd"},   32'(avm_read), 32'(!is_wr));
      if (is_wr) chk({tag, ".wdata"}, avm_writedata, m_mon);
      avm_waitrequest      = (cycles <= stalls);
      avm_readdata         = (cycles <= stalls) ? ~rdata : rdata;
      take_action_ocimem_b = (cycles == busy_at);
      @(negedge clk);
    end
    take_action_ocimem_b = 1'b0;
    avm_waitrequest      = 1'b0;
    exp_cycles = !launches ? 0 : (stalls < TO ? stalls + 1 : TO);
    if (busy_at >= 1 && busy_at <= exp_cycles) m_err = 1;
    if (launches) begin
      m_ready = 1;
      if (stalls < TO) begin
        if (!is_wr) m_mon = rdata;
        if (m_inc) m_addr = (m_addr + 1) % (1 << ADDR_W);
      end else begin
        m_err = 1;
      end
    end
    chk({tag, ".cycles"}, 32'(cycles), 32'(exp_cycles));
    check_idle(tag);
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.wdata", avm_writedata, 32'd0);
    check_idle("rst");
    reset = 1'b0;

    // Directed write with three stall cycles.
    action_a(1, 0, 'h012);
    transfer(1, 3, 32'hDEADBEEF, 32'h0, 0, "wr");

    // Streaming read across the address wrap.
    action_a(0, 1, 'h1FF);
    transfer(2, 1, 32'h0, 32'h12345678, 0, "srd0");
    transfer(2, 0, 32'h0, 32'hCAFEF00D, 0, "srd1");

    // Timeout: slave never releases waitrequest.
    action_a(0, 0, 'h0AA);
    transfer(1, 10, 32'h0, 32'h55555555, 0, "tmo");

    // Strobe while busy is dropped; the write still completes exactly once.
    action_a(1, 0, 'h033);
    transfer(1, 2, 32'hA5A50F0F, 32'h0, 2, "busy");
    repeat (3) begin
      @(negedge clk);
      chk("busy.no_second_write", 32'(avm_write), 32'd0);
    end

    // All three strobes at once: only the address load happens.
    @(negedge clk);
    jdo = {6'($urandom), $urandom};
    jdo[35] = 1'b1; jdo[34] = 1'b0; jdo[25:17] = 9'h055;
    take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1; take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    m_addr = 'h055; m_wr = 1; m_inc = 0; m_ready = 0; m_err = 0;
    check_idle("prio");
    // no_action_a in write mode does nothing.
    transfer(2, 0, 32'h0, 32'h0, 0, "nact_wr");

    // Randomized sequences.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        action_a(1'($urandom), 1'($urandom), int'($urandom_range(0, 511)));
      transfer(int'($urandom_range(1, 2)), int'($urandom_range(0, 6)), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rnd");
    end

    // Reset in the middle of a stalled read.
    action_a(0, 0, 'h101);
    @(negedge clk);
    take_action_ocimem_b = 1'b1;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    chk("rstrd.read_before", 32'(avm_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_idle("rstrd");
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_idle("rstrd.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
